// File: rtl/lane_vrf_write_pkg.sv
// lane_vrf_write_pkg: shared widths and the write-request payload type for the lane VRF write arbiter.
package lane_vrf_write_pkg;
  localparam int NUM_REQ_MAX = 8;
  localparam int REQ_VD_W = 5;
  localparam int REQ_OFFSET_W = 3;
  localparam int REQ_DATA_W = 32;
  localparam int REQ_INST_W = 3;
  typedef struct packed {
    logic [REQ_VD_W-1:0]     vd;
    logic [REQ_OFFSET_W-1:0] offset;
    logic [REQ_DATA_W/8-1:0] mask;
    logic [REQ_DATA_W-1:0]   data;
    logic                    last;
    logic [REQ_INST_W-1:0]   instructionIndex;
  } vrf_write_req_t;
endpackage

// File: rtl/rr_arbiter_core.sv
// rr_arbiter_core: round-robin pointer and one-hot grant, searching upward from the pointer with wrap.
module rr_arbiter_core #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic found;
  always_comb begin
    grant_oh = '0;
    grant_idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(rr_ptr_q) + k) % N]) begin
        found = 1'b1;
        grant_oh[(int'(rr_ptr_q) + k) % N] = 1'b1;
        grant_idx = IW'((int'(rr_ptr_q) + k) % N);
      end
    end
    rr_ptr_d = advance ? IW'((int'(grant_idx) + 1) % N) : rr_ptr_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rr_ptr_q <= '0;
    else rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/lane_vrf_write_arbiter.sv
// lane_vrf_write_arbiter: round-robin share of one VRF write port behind a single registered output stage.
// LANE_VRF_WRITE_ARB_PERF_EN adds per-requester saturating stall counters on perf_stall_cnt.
module lane_vrf_write_arbiter
  import lane_vrf_write_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int VD_W     = REQ_VD_W,
  parameter int OFFSET_W = REQ_OFFSET_W,
  parameter int DATA_W   = REQ_DATA_W,
  parameter int INST_W   = REQ_INST_W,
  parameter int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*VD_W-1:0]    req_vd,
  input  logic [NUM_REQ*OFFSET_W-1:0] req_offset,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_mask,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*INST_W-1:0]  req_instructionIndex,
  input  logic                       vrfWriteRequest_ready,
  output logic                       vrfWriteRequest_valid,
  output logic [VD_W-1:0]            vrfWriteRequest_bits_vd,
  output logic [OFFSET_W-1:0]        vrfWriteRequest_bits_offset,
  output logic [DATA_W/8-1:0]        vrfWriteRequest_bits_mask,
  output logic [DATA_W-1:0]          vrfWriteRequest_bits_data,
  output logic                       vrfWriteRequest_bits_last,
  output logic [INST_W-1:0]          vrfWriteRequest_bits_instructionIndex,
  output logic [IW-1:0]              grant_id
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
  ,
  output logic [NUM_REQ*16-1:0]      perf_stall_cnt
`endif
);
  localparam int MASK_W = DATA_W / 8;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IW-1:0] grant_idx, grant_id_q;
  logic free, accept, valid_q;
  vrf_write_req_t out_q, out_d;
  assign free = ~valid_q | vrfWriteRequest_ready;
  assign req_ready = reset ? '0 : (grant_oh & {NUM_REQ{free}});
  assign accept = |(req_valid & req_ready);
  rr_arbiter_core #(.N(NUM_REQ), .IW(IW)) u_rr (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .advance  (accept),
    .grant_oh (grant_oh),
    .grant_idx(grant_idx)
  );
  always_comb begin
    out_d.vd = req_vd[grant_idx*VD_W +: VD_W];
    out_d.offset = req_offset[grant_idx*OFFSET_W +: OFFSET_W];
    out_d.mask = req_mask[grant_idx*MASK_W +: MASK_W];
    out_d.data = req_data[grant_idx*DATA_W +: DATA_W];
    out_d.last = req_last[grant_idx];
    out_d.instructionIndex = req_instructionIndex[grant_idx*INST_W +: INST_W];
  end
  // A held entry (valid & ~ready) blocks accept via free, so it stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q <= '0;
      grant_id_q <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      out_q <= out_d;
      grant_id_q <= grant_idx;
    end else if (vrfWriteRequest_ready) begin
      valid_q <= 1'b0;
    end
  end
  assign vrfWriteRequest_valid = valid_q;
  assign vrfWriteRequest_bits_vd = out_q.vd;
  assign vrfWriteRequest_bits_offset = out_q.offset;
  assign vrfWriteRequest_bits_mask = out_q.mask;
  assign vrfWriteRequest_bits_data = out_q.data;
  assign vrfWriteRequest_bits_last = out_q.last;
  assign vrfWriteRequest_bits_instructionIndex = out_q.instructionIndex;
  assign grant_id = grant_id_q;
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
  logic [NUM_REQ-1:0][15:0] stall_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_q <= '0;
    else
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] & ~req_ready[i] & ~&stall_q[i]) stall_q[i] <= stall_q[i] + 16'd1;
  end
  assign perf_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// tb_lane_vrf_write_arbiter: scenario tasks plus a queue scoreboard popped on each VRF handshake.
module tb_lane_vrf_write_arbiter;
  localparam int N = 4, VD_W = 5, OW = 3, DW = 32, MW = 4, IIW = 3;
  typedef struct packed {
    logic [1:0] gid;
    logic [4:0] vd;
    logic [2:0] off;
    logic [3:0] mask;
    logic [31:0] data;
    logic last;
    logic [2:0] ii;
  } exp_t;
  logic clock = 1'b0, reset = 1'b1, vrf_ready = 1'b1;
  logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [N*VD_W-1:0] req_vd = '0;
  logic [N*OW-1:0] req_offset = '0;
  logic [N*MW-1:0] req_mask = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*IIW-1:0] req_ii = '0;
  logic o_valid, o_last;
  logic [4:0] o_vd;
  logic [2:0] o_off, o_ii;
  logic [3:0] o_mask;
  logic [31:0] o_data;
  logic [1:0] o_gid;
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
  logic [N*16-1:0] perf_cnt;
`endif
  exp_t exp_q[$];
  int errors = 0, checks = 0;
  always #5 clock = ~clock;
  lane_vrf_write_arbiter dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_vd(req_vd), .req_offset(req_offset), .req_mask(req_mask), .req_data(req_data),
    .req_last(req_last), .req_instructionIndex(req_ii), .vrfWriteRequest_ready(vrf_ready),
    .vrfWriteRequest_valid(o_valid), .vrfWriteRequest_bits_vd(o_vd),
    .vrfWriteRequest_bits_offset(o_off), .vrfWriteRequest_bits_mask(o_mask),
    .vrfWriteRequest_bits_data(o_data), .vrfWriteRequest_bits_last(o_last),
    .vrfWriteRequest_bits_instructionIndex(o_ii), .grant_id(o_gid)
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
    , .perf_stall_cnt(perf_cnt)
`endif
  );
  always @(negedge clock) begin : monitor
    exp_t got, e;
    if (!reset && o_valid && vrf_ready) begin
      got = {o_gid, o_vd, o_off, o_mask, o_data, o_last, o_ii};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected got=%h", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL scoreboard_payload got=%h exp=%h", got, e);
        end
      end
    end
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic exp_t exp_of(int i);
    exp_t e;
    e.gid = 2'(i);
    e.vd = req_vd[i*VD_W +: VD_W];
    e.off = req_offset[i*OW +: OW];
    e.mask = req_mask[i*MW +: MW];
    e.data = req_data[i*DW +: DW];
    e.last = req_last[i];
    e.ii = req_ii[i*IIW +: IIW];
    return e;
  endfunction
  task automatic set_req(input int i, input logic [4:0] vd, input logic [2:0] off,
                         input logic [3:0] mask, input logic [31:0] data, input logic last,
                         input logic [2:0] ii);
    req_vd[i*VD_W +: VD_W] = vd;
    req_offset[i*OW +: OW] = off;
    req_mask[i*MW +: MW] = mask;
    req_data[i*DW +: DW] = data;
    req_last[i] = last;
    req_ii[i*IIW +: IIW] = ii;
  endtask
  task automatic rand_payload(input int i);
    set_req(i, 5'($urandom), 3'($urandom), 4'($urandom), $urandom, 1'($urandom), 3'($urandom));
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic apply_reset;
    @(posedge clock);
    #3 reset = 1'b1;
    req_valid = '0;
    vrf_ready = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    exp_q.delete();
  endtask
  task automatic drain;
    req_valid = '0;
    repeat (3) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queue got=%0d exp=0", exp_q.size());
    end
  endtask
  task automatic test_reset;
    for (int i = 0; i < N; i++) rand_payload(i);
    req_valid = 4'b1111;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    checks++; if ({o_valid, o_gid, o_data, o_vd} !== '0) begin errors++; $display("FAIL reset_outputs got=%b/%0d/%h/%0d exp=0", o_valid, o_gid, o_data, o_vd); end
    req_valid = 4'b1110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_ptr0 got=%b exp=0010", req_ready); end
    req_valid = 4'b0100;
    vrf_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL reset_req2 got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b1111;
    #1;
    checks++; if (o_valid !== 1'b1 || o_data !== req_data[2*DW +: DW]) begin errors++; $display("FAIL reset_held got=%b/%h exp=1/%h", o_valid, o_data, req_data[2*DW +: DW]); end
    reset = 1'b1;
    #1;
    checks++; if ({o_valid, o_gid, o_data} !== '0 || req_ready !== 4'b0000) begin errors++; $display("FAIL reset_async got=%b/%0d/%h/%b exp=0/0/0/0000", o_valid, o_gid, o_data, req_ready); end
    #2 reset = 1'b0;
    req_valid = 4'b1110;
    vrf_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_ptr_cleared got=%b exp=0010", req_ready); end
    exp_q.push_back(exp_of(1));
    step();
    drain();
  endtask
  task automatic test_round_robin;
    apply_reset();
    for (int i = 0; i < N; i++) rand_payload(i);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, 4'(1 << (k % 4))); end
      exp_q.push_back(exp_of(k % 4));
      step();
      checks++; if (o_valid !== 1'b1 || o_gid !== 2'(k % 4)) begin errors++; $display("FAIL rr_nobubble%0d got=%b/%0d exp=1/%0d", k, o_valid, o_gid, k % 4); end
      rand_payload(k % 4);
    end
    drain();
  endtask
  task automatic test_backpressure;
    apply_reset();
    set_req(0, 5'd5, 3'd3, 4'hF, 32'hDEADBEEF, 1'b0, 3'd1);
    rand_payload(1);
    req_valid = 4'b0001;
    #1;
    exp_q.push_back(exp_of(0));
    step();
    vrf_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (o_valid !== 1'b1 || o_vd !== 5'd5 || o_off !== 3'd3 || o_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold%0d got=%b/%0d/%0d/%h exp=1/5/3/deadbeef", k, o_valid, o_vd, o_off, o_data); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d got=%b exp=0000", k, req_ready); end
      step();
    end
    vrf_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
    exp_q.push_back(exp_of(1));
    step();
    checks++; if (o_valid !== 1'b1 || o_gid !== 2'd1) begin errors++; $display("FAIL bp_next got=%b/%0d exp=1/1", o_valid, o_gid); end
    drain();
  endtask
  task automatic test_single;
    apply_reset();
    rand_payload(1);
    rand_payload(2);
    req_valid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single%0d got=%b exp=0100", k, req_ready); end
      exp_q.push_back(exp_of(2));
      step();
      rand_payload(2);
    end
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_wrap got=%b exp=0010", req_ready); end
    exp_q.push_back(exp_of(1));
    step();
    drain();
  endtask
  task automatic test_last_mask;
    set_req(3, 5'h1F, 3'h7, 4'b0000, 32'hA5A50F0F, 1'b1, 3'h6);
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL lm_grant got=%b exp=1000", req_ready); end
    exp_q.push_back(exp_of(3));
    step();
    checks++; if (o_last !== 1'b1 || o_mask !== 4'b0000 || o_ii !== 3'h6 || o_gid !== 2'd3) begin errors++; $display("FAIL lm_fields got=%b/%b/%0d/%0d exp=1/0000/6/3", o_last, o_mask, o_ii, o_gid); end
    drain();
  endtask
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
  task automatic test_perf;
    apply_reset();
    rand_payload(0);
    rand_payload(1);
    req_valid = 4'b0001;
    vrf_ready = 1'b0;
    #1;
    exp_q.push_back(exp_of(0));
    step();
    req_valid = 4'b0010;
    repeat (20) step();
    req_valid = 4'b0000;
    #1;
    checks++; if (perf_cnt[31:16] !== 16'd20 || perf_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL perf_20 got=%0d/%0d exp=20/0", perf_cnt[31:16], perf_cnt[15:0]); end
    req_valid = 4'b0010;
    repeat (70000) step();
    #1;
    checks++; if (perf_cnt[31:16] !== 16'hFFFF) begin errors++; $display("FAIL perf_sat got=%h exp=ffff", perf_cnt[31:16]); end
    vrf_ready = 1'b1;
    exp_q.push_back(exp_of(1));
    step();
    drain();
  endtask
`endif
  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_single();
    test_last_mask();
`ifdef LANE_VRF_WRITE_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
